// File: rtl/exec_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : exec_multicycle
// Purpose  : Execute stage of the swt16 pipeline. Encoded ALU op set, an
//            iterative shift-add multiplier that stalls decode, jump/branch
//            resolution with wrong-path squash, and DMEM address/data drive.
//            Every output is registered.
// Ports    : clock / reset (async, active-low)
//            in_valid, in_alu_op, in_act_*        - decoded instruction slot
//            in_pc, in_branch_tgt                 - instruction PC / target
//            in_res_reg_idx, in_src1, in_src2     - destination and operands
//            out_stall                            - decode must hold its slot
//            out_valid, out_res, out_res_reg_idx  - committed result lane
//            out_act_*                            - pass-through actions
//            out_dmem_rd_addr/_wr_addr/_wr_word   - data memory drive
//            out_flush, out_set_pc, out_new_pc    - fetch redirect
// Revision : 1.0 - initial release
// ============================================================================
module exec_multicycle #(
  parameter int IALU_WORD_WIDTH = 16,
  parameter int ALU_OP_WIDTH    = 4,
  parameter int REG_IDX_WIDTH   = 4,
  parameter int PC_WIDTH        = 12,
  parameter int PC_INCREMENT    = 2,
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [ALU_OP_WIDTH-1:0]    in_alu_op,
  input  logic                       in_act_incr_pc_is_res,
  input  logic                       in_act_jump,
  input  logic                       in_act_branch_eq,
  input  logic                       in_act_branch_ne,
  input  logic                       in_act_load_dmem,
  input  logic                       in_act_store_dmem,
  input  logic                       in_act_write_res_to_reg,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [PC_WIDTH-1:0]        in_branch_tgt,
  input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
  input  logic [IALU_WORD_WIDTH-1:0] in_src1,
  input  logic [IALU_WORD_WIDTH-1:0] in_src2,
  output logic                       out_stall,
  output logic                       out_valid,
  output logic [IALU_WORD_WIDTH-1:0] out_res,
  output logic [REG_IDX_WIDTH-1:0]   out_res_reg_idx,
  output logic                       out_act_load_dmem,
  output logic                       out_act_store_dmem,
  output logic                       out_act_write_res_to_reg,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_rd_addr,
  output logic [DMEM_ADDR_WIDTH-1:0] out_dmem_wr_addr,
  output logic [IALU_WORD_WIDTH-1:0] out_dmem_wr_word,
  output logic                       out_flush,
  output logic                       out_set_pc,
  output logic [PC_WIDTH-1:0]        out_new_pc
);

  localparam int c_SHAMT_W = $clog2(IALU_WORD_WIDTH);
  localparam int c_CNT_W   = $clog2(IALU_WORD_WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(IALU_WORD_WIDTH - 1);

  localparam logic [0:0] c_ST_IDLE     = 1'b0;
  localparam logic [0:0] c_ST_MUL_BUSY = 1'b1;

  localparam logic [ALU_OP_WIDTH-1:0] c_OP_ADD   = ALU_OP_WIDTH'(1);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SUB   = ALU_OP_WIDTH'(2);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_AND   = ALU_OP_WIDTH'(3);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_OR    = ALU_OP_WIDTH'(4);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_XOR   = ALU_OP_WIDTH'(5);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SHL   = ALU_OP_WIDTH'(6);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_SHR   = ALU_OP_WIDTH'(7);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_PASS2 = ALU_OP_WIDTH'(8);
  localparam logic [ALU_OP_WIDTH-1:0] c_OP_MUL   = ALU_OP_WIDTH'(9);

  logic [0:0]                 r_state, w_state_nxt;
  logic [c_CNT_W-1:0]         r_cnt;
  logic [IALU_WORD_WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_nxt;

  // Pass-through fields of an in-flight MUL, replayed when its result lands.
  logic [REG_IDX_WIDTH-1:0]   r_mul_idx;
  logic                       r_mul_ld, r_mul_st, r_mul_wr;
  logic [DMEM_ADDR_WIDTH-1:0] r_mul_rd_addr, r_mul_wr_addr;
  logic [IALU_WORD_WIDTH-1:0] r_mul_wr_word;

  logic [IALU_WORD_WIDTH-1:0] w_alu_res, w_res, w_wr_word;
  logic [PC_WIDTH-1:0]        w_link_pc, w_tgt_pc;
  logic [DMEM_ADDR_WIDTH-1:0] w_rd_addr, w_wr_addr;
  logic w_live, w_is_mul, w_mul_start, w_br_taken, w_redirect;

  // Registered output values and their next-cycle counterparts.
  logic                       r_stall, r_valid, r_ld, r_st, r_wr, r_flush;
  logic [IALU_WORD_WIDTH-1:0] r_res, r_wr_word;
  logic [REG_IDX_WIDTH-1:0]   r_idx;
  logic [DMEM_ADDR_WIDTH-1:0] r_rd_addr, r_wr_addr;
  logic [PC_WIDTH-1:0]        r_new_pc;
  logic                       w_nxt_stall, w_nxt_valid, w_nxt_ld, w_nxt_st, w_nxt_wr, w_nxt_flush;
  logic [IALU_WORD_WIDTH-1:0] w_nxt_res, w_nxt_wr_word;
  logic [REG_IDX_WIDTH-1:0]   w_nxt_idx;
  logic [DMEM_ADDR_WIDTH-1:0] w_nxt_rd_addr, w_nxt_wr_addr;
  logic [PC_WIDTH-1:0]        w_nxt_new_pc;

  // ---------------------------------------------------------------- ALU ----
  always_comb begin
    w_alu_res = '0;
    case (in_alu_op)
      c_OP_ADD:   w_alu_res = in_src1 + in_src2;
      c_OP_SUB:   w_alu_res = in_src1 - in_src2;
      c_OP_AND:   w_alu_res = in_src1 & in_src2;
      c_OP_OR:    w_alu_res = in_src1 | in_src2;
      c_OP_XOR:   w_alu_res = in_src1 ^ in_src2;
      c_OP_SHL:   w_alu_res = in_src1 << in_src2[c_SHAMT_W-1:0];
      c_OP_SHR:   w_alu_res = in_src1 >> in_src2[c_SHAMT_W-1:0];
      c_OP_PASS2: w_alu_res = in_src2;
      default:    w_alu_res = '0;  // NOP, undefined; MUL comes from the iterator
    endcase
  end

  assign w_link_pc = in_pc + PC_WIDTH'(PC_INCREMENT);
  assign w_res     = in_act_incr_pc_is_res ? IALU_WORD_WIDTH'(w_link_pc) : w_alu_res;
  assign w_rd_addr = in_act_load_dmem  ? in_src1[DMEM_ADDR_WIDTH-1:0] : '0;
  assign w_wr_addr = in_act_store_dmem ? in_src2[DMEM_ADDR_WIDTH-1:0] : '0;
  assign w_wr_word = in_act_store_dmem ? in_src1 : '0;

  // A slot is live when the stage is sampling, it is valid, and it is not the
  // wrong-path slot right behind a redirect (out_flush is high exactly then).
  assign w_live      = (r_state == c_ST_IDLE) & in_valid & ~r_flush;
  assign w_is_mul    = (in_alu_op == c_OP_MUL);
  assign w_mul_start = w_live & w_is_mul;

  // EQ takes precedence when both branch kinds are flagged.
  assign w_br_taken = in_act_branch_eq ? (in_src1 == in_src2)
                                       : (in_act_branch_ne & (in_src1 != in_src2));
  // Control-flow actions on a MUL slot are not honoured.
  assign w_redirect = w_live & ~w_is_mul & (in_act_jump | w_br_taken);
  assign w_tgt_pc   = in_act_jump ? w_alu_res[PC_WIDTH-1:0] : in_branch_tgt;

  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);

  // ---------------------------------------------------------------- FSM ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= c_ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:     if (w_mul_start) w_state_nxt = c_ST_MUL_BUSY;
      c_ST_MUL_BUSY: if (r_cnt == c_CNT_LAST) w_state_nxt = c_ST_IDLE;
      default:       w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_nxt_stall   = 1'b0;
    w_nxt_valid   = 1'b0;
    w_nxt_res     = '0;
    w_nxt_idx     = '0;
    w_nxt_ld      = 1'b0;
    w_nxt_st      = 1'b0;
    w_nxt_wr      = 1'b0;
    w_nxt_rd_addr = '0;
    w_nxt_wr_addr = '0;
    w_nxt_wr_word = '0;
    w_nxt_flush   = 1'b0;
    w_nxt_new_pc  = '0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_mul_start) begin
          w_nxt_stall = 1'b1;
        end else if (w_live) begin
          w_nxt_valid   = 1'b1;
          w_nxt_res     = w_res;
          w_nxt_idx     = in_res_reg_idx;
          w_nxt_ld      = in_act_load_dmem;
          w_nxt_st      = in_act_store_dmem;
          w_nxt_wr      = in_act_write_res_to_reg;
          w_nxt_rd_addr = w_rd_addr;
          w_nxt_wr_addr = w_wr_addr;
          w_nxt_wr_word = w_wr_word;
          w_nxt_flush   = w_redirect;
          w_nxt_new_pc  = w_redirect ? w_tgt_pc : '0;
        end
      end
      c_ST_MUL_BUSY: begin
        if (r_cnt == c_CNT_LAST) begin
          // Final step's sum goes straight to the result lane.
          w_nxt_valid   = 1'b1;
          w_nxt_res     = w_acc_nxt;
          w_nxt_idx     = r_mul_idx;
          w_nxt_ld      = r_mul_ld;
          w_nxt_st      = r_mul_st;
          w_nxt_wr      = r_mul_wr;
          w_nxt_rd_addr = r_mul_rd_addr;
          w_nxt_wr_addr = r_mul_wr_addr;
          w_nxt_wr_word = r_mul_wr_word;
        end else begin
          w_nxt_stall = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------- registers --
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall   <= 1'b0;
      r_valid   <= 1'b0;
      r_res     <= '0;
      r_idx     <= '0;
      r_ld      <= 1'b0;
      r_st      <= 1'b0;
      r_wr      <= 1'b0;
      r_rd_addr <= '0;
      r_wr_addr <= '0;
      r_wr_word <= '0;
      r_flush   <= 1'b0;
      r_new_pc  <= '0;
    end else begin
      r_stall   <= w_nxt_stall;
      r_valid   <= w_nxt_valid;
      r_res     <= w_nxt_res;
      r_idx     <= w_nxt_idx;
      r_ld      <= w_nxt_ld;
      r_st      <= w_nxt_st;
      r_wr      <= w_nxt_wr;
      r_rd_addr <= w_nxt_rd_addr;
      r_wr_addr <= w_nxt_wr_addr;
      r_wr_word <= w_nxt_wr_word;
      r_flush   <= w_nxt_flush;
      r_new_pc  <= w_nxt_new_pc;
    end
  end

  // Shift-add multiplier: one multiplier bit consumed per busy edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_mcand       <= '0;
      r_mplier      <= '0;
      r_mul_idx     <= '0;
      r_mul_ld      <= 1'b0;
      r_mul_st      <= 1'b0;
      r_mul_wr      <= 1'b0;
      r_mul_rd_addr <= '0;
      r_mul_wr_addr <= '0;
      r_mul_wr_word <= '0;
    end else if (w_mul_start) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_mcand       <= in_src1;
      r_mplier      <= in_src2;
      r_mul_idx     <= in_res_reg_idx;
      r_mul_ld      <= in_act_load_dmem;
      r_mul_st      <= in_act_store_dmem;
      r_mul_wr      <= in_act_write_res_to_reg;
      r_mul_rd_addr <= w_rd_addr;
      r_mul_wr_addr <= w_wr_addr;
      r_mul_wr_word <= w_wr_word;
    end else if (r_state == c_ST_MUL_BUSY) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + c_CNT_W'(1);
    end
  end

  assign out_stall                = r_stall;
  assign out_valid                = r_valid;
  assign out_res                  = r_res;
  assign out_res_reg_idx          = r_idx;
  assign out_act_load_dmem        = r_ld;
  assign out_act_store_dmem       = r_st;
  assign out_act_write_res_to_reg = r_wr;
  assign out_dmem_rd_addr         = r_rd_addr;
  assign out_dmem_wr_addr         = r_wr_addr;
  assign out_dmem_wr_word         = r_wr_word;
  assign out_flush                = r_flush;
  assign out_set_pc               = r_flush;
  assign out_new_pc               = r_new_pc;

endmodule
`default_nettype wire

// File: tb/tb_exec_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_multicycle
// Purpose  : Self-checking bench for exec_multicycle. A driver issues directed
//            and random instructions, a reference model predicts each committed
//            output into a scoreboard queue, and a monitor compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_multicycle;
  localparam int W = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid, in_act_incr_pc_is_res, in_act_jump, in_act_branch_eq, in_act_branch_ne;
  logic        in_act_load_dmem, in_act_store_dmem, in_act_write_res_to_reg;
  logic [3:0]  in_alu_op, in_res_reg_idx;
  logic [11:0] in_pc, in_branch_tgt;
  logic [15:0] in_src1, in_src2;
  logic        out_stall, out_valid, out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg;
  logic        out_flush, out_set_pc;
  logic [15:0] out_res, out_dmem_wr_word;
  logic [3:0]  out_res_reg_idx;
  logic [11:0] out_dmem_rd_addr, out_dmem_wr_addr, out_new_pc;

  exec_multicycle dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_alu_op(in_alu_op),
    .in_act_incr_pc_is_res(in_act_incr_pc_is_res), .in_act_jump(in_act_jump),
    .in_act_branch_eq(in_act_branch_eq), .in_act_branch_ne(in_act_branch_ne),
    .in_act_load_dmem(in_act_load_dmem), .in_act_store_dmem(in_act_store_dmem),
    .in_act_write_res_to_reg(in_act_write_res_to_reg), .in_pc(in_pc),
    .in_branch_tgt(in_branch_tgt), .in_res_reg_idx(in_res_reg_idx),
    .in_src1(in_src1), .in_src2(in_src2), .out_stall(out_stall), .out_valid(out_valid),
    .out_res(out_res), .out_res_reg_idx(out_res_reg_idx),
    .out_act_load_dmem(out_act_load_dmem), .out_act_store_dmem(out_act_store_dmem),
    .out_act_write_res_to_reg(out_act_write_res_to_reg),
    .out_dmem_rd_addr(out_dmem_rd_addr), .out_dmem_wr_addr(out_dmem_wr_addr),
    .out_dmem_wr_word(out_dmem_wr_word), .out_flush(out_flush), .out_set_pc(out_set_pc),
    .out_new_pc(out_new_pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        valid, link, jump, beq, bne, ld, st, wr;
    logic [3:0]  op, idx;
    logic [11:0] pc, tgt;
    logic [15:0] s1, s2;
  } instr_t;

  typedef struct {
    int          cyc;
    logic [15:0] res, wr_word;
    logic [3:0]  idx;
    logic        ld, st, wr, redir;
    logic [11:0] rd_addr, wr_addr, new_pc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   mul_start = -1000;   // edge at which the model last accepted a MUL
  bit   pend_squash = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic instr_t mk(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    instr_t t;
    t.valid = 1'b1; t.op = op; t.link = 1'b0; t.jump = 1'b0; t.beq = 1'b0; t.bne = 1'b0;
    t.ld = 1'b0; t.st = 1'b0; t.wr = 1'b1; t.idx = 4'd3; t.pc = 12'h100; t.tgt = 12'h000;
    t.s1 = a; t.s2 = b;
    return t;
  endfunction

  function automatic instr_t bubble();
    instr_t t;
    t = mk(4'd0, 16'h0, 16'h0);
    t.valid = 1'b0;
    t.wr = 1'b0;
    return t;
  endfunction

  function automatic instr_t rnd();
    instr_t t;
    int k;
    t = mk(4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
    if ($urandom_range(0, 4) == 0) t.op = 4'd9;
    k = $urandom_range(0, 7);
    if (k == 0) t.s1 = 16'hFFFF;
    if (k == 1) t.s2 = 16'h0000;
    if (k >= 5) t.s2 = t.s1;
    t.valid = ($urandom_range(0, 9) != 0);
    t.idx = 4'($urandom); t.pc = 12'($urandom); t.tgt = 12'($urandom);
    t.ld = 1'($urandom); t.st = 1'($urandom); t.wr = 1'($urandom);
    if (t.op != 4'd9) begin
      t.link = ($urandom_range(0, 3) == 0);
      k = $urandom_range(0, 7);
      t.jump = (k == 1);
      t.beq  = (k == 2) || (k == 4);
      t.bne  = (k == 3) || (k == 4);
    end
    return t;
  endfunction

  // Reference result: plain arithmetic truncated to the word width.
  function automatic logic [15:0] ref_alu(input instr_t t);
    longint unsigned a = t.s1, b = t.s2, r;
    case (t.op)
      4'd1: r = a + b;
      4'd2: r = a - b;
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6: r = a << (b % 16);
      4'd7: r = a >> (b % 16);
      4'd8: r = b;
      4'd9: r = a * b;
      default: r = 0;
    endcase
    return r[15:0];
  endfunction

  task automatic model_step(input instr_t t, input int e);
    exp_t x;
    logic [15:0] alu;
    bit taken;
    if (pend_squash) begin pend_squash = 1'b0; return; end
    if (!t.valid) return;
    x.idx = t.idx; x.ld = t.ld; x.st = t.st; x.wr = t.wr;
    x.rd_addr = t.ld ? t.s1[11:0] : 12'h0;
    x.wr_addr = t.st ? t.s2[11:0] : 12'h0;
    x.wr_word = t.st ? t.s1 : 16'h0;
    alu = ref_alu(t);
    if (t.op == 4'd9) begin
      mul_start = e;
      x.cyc = e + W; x.res = alu; x.redir = 1'b0; x.new_pc = 12'h0;
    end else begin
      x.cyc = e;
      x.res = t.link ? 16'((int'(t.pc) + 2) % 4096) : alu;
      taken = t.beq ? (t.s1 == t.s2) : (t.bne && (t.s1 != t.s2));
      x.redir = t.jump || taken;
      x.new_pc = t.jump ? alu[11:0] : (taken ? t.tgt : 12'h0);
      if (x.redir) pend_squash = 1'b1;
    end
    sb.push_back(x);
  endtask

  task automatic drive(input instr_t t);
    in_valid = t.valid; in_alu_op = t.op; in_act_incr_pc_is_res = t.link;
    in_act_jump = t.jump; in_act_branch_eq = t.beq; in_act_branch_ne = t.bne;
    in_act_load_dmem = t.ld; in_act_store_dmem = t.st; in_act_write_res_to_reg = t.wr;
    in_pc = t.pc; in_branch_tgt = t.tgt; in_res_reg_idx = t.idx;
    in_src1 = t.s1; in_src2 = t.s2;
  endtask

  function automatic bit model_stalled();
    return (cyc >= mul_start) && (cyc < mul_start + W);
  endfunction

  // Issue one instruction; while the model says decode is stalled, junk is
  // driven to confirm the stage ignores its inputs.
  task automatic send(input instr_t t);
    forever begin
      @(negedge clock);
      if (!model_stalled()) break;
      drive(rnd());
    end
    drive(t);
    @(posedge clock);
    #1;
    model_step(t, cyc);
    drive(bubble());
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(out_stall), 32'h0);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_res"}, 32'(out_res), 32'h0);
    chk({tag, "_acts"}, 32'({out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg}), 32'h0);
    chk({tag, "_dmem"}, 32'({out_dmem_rd_addr, out_dmem_wr_addr}), 32'h0);
    chk({tag, "_redirect"}, 32'({out_flush, out_set_pc, out_new_pc}), 32'h0);
  endtask

  // Monitor: compares every cycle, popping the scoreboard on out_valid.
  initial begin
    exp_t x;
    forever begin
      @(negedge clock);
      if (reset) begin
        chk("stall", 32'(out_stall), 32'(model_stalled()));
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
          x = sb.pop_front();
          n_tests++; n_fail++;
          $display("FAIL missing_output @cyc %0d: got no valid result, expected res 0x%0h at cyc %0d", cyc, x.res, x.cyc);
        end
        if (out_valid) begin
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_valid @cyc %0d: got res 0x%0h, expected no output", cyc, out_res);
          end else begin
            x = sb.pop_front();
            chk("latency", 32'(cyc), 32'(x.cyc));
            chk("res", 32'(out_res), 32'(x.res));
            chk("reg_idx", 32'(out_res_reg_idx), 32'(x.idx));
            chk("act_load", 32'(out_act_load_dmem), 32'(x.ld));
            chk("act_store", 32'(out_act_store_dmem), 32'(x.st));
            chk("act_wr", 32'(out_act_write_res_to_reg), 32'(x.wr));
            chk("rd_addr", 32'(out_dmem_rd_addr), 32'(x.rd_addr));
            chk("wr_addr", 32'(out_dmem_wr_addr), 32'(x.wr_addr));
            chk("wr_word", 32'(out_dmem_wr_word), 32'(x.wr_word));
            chk("flush", 32'(out_flush), 32'(x.redir));
            chk("set_pc", 32'(out_set_pc), 32'(x.redir));
            chk("new_pc", 32'(out_new_pc), 32'(x.new_pc));
          end
        end else begin
          chk("idle_acts", 32'({out_act_load_dmem, out_act_store_dmem, out_act_write_res_to_reg,
                                out_flush, out_set_pc}), 32'h0);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    instr_t t;
    drive(bubble());
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset = 1'b1;

    send(mk(4'd1, 16'h1234, 16'h0F0F));              // ADD -> 0x2143
    send(mk(4'd2, 16'h0000, 16'h0001));              // SUB -> 0xFFFF
    send(mk(4'd6, 16'h0001, 16'h000F));              // SHL -> 0x8000
    send(mk(4'd9, 16'h0123, 16'h0010));              // MUL -> 0x1230
    send(mk(4'd9, 16'hFFFF, 16'hFFFF));              // MUL -> 0x0001
    send(mk(4'd1, 16'h0101, 16'h0202));              // ADD held through the stall
    t = mk(4'd0, 16'h0005, 16'h0005); t.beq = 1'b1; t.tgt = 12'h040; t.wr = 1'b0;
    send(t);                                          // BEQ taken
    t = mk(4'd0, 16'h0ABC, 16'h0123); t.st = 1'b1; t.wr = 1'b0;
    send(t);                                          // squashed STORE
    t = mk(4'd1, 16'h1111, 16'h2222); t.link = 1'b1; t.pc = 12'hFFE;
    send(t);                                          // link wraps to 0x0000
    t = mk(4'd8, 16'h0000, 16'h0BEE); t.ld = 1'b1; t.st = 1'b1; t.s1 = 16'h0777;
    send(t);                                          // PASS2 with load+store

    // Reset in the middle of a multiply.
    send(mk(4'd9, 16'h1234, 16'h5678));
    repeat (7) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check_all_zero("mid_mul_reset");
    sb.delete();
    mul_start = -1000;
    pend_squash = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    send(mk(4'd1, 16'h00FF, 16'h0001));              // ADD -> 0x0100

    for (int i = 0; i < 400; i++) send(rnd());

    repeat (W + 4) @(negedge clock);
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
